// File: rtl/remove_header_if.sv
// AXI-Stream in/out bundle plus status for the header-strip stage.
// slave = the stripping block, master = the upstream/downstream side driving it.
interface remove_header_if #(
    parameter int DW = 128
);
    logic [DW-1:0]   axis_in_tdata;
    logic [DW/8-1:0] axis_in_tkeep;
    logic            axis_in_tlast;
    logic            axis_in_tvalid;
    logic            axis_in_tready;

    logic [DW-1:0]   axis_out_tdata;
    logic [DW/8-1:0] axis_out_tkeep;
    logic            axis_out_tlast;
    logic            axis_out_tvalid;
    logic            axis_out_tready;

    logic            pkt_done;
    logic            err_len;
    logic [31:0]     pkt_count;
    logic [15:0]     err_count;

    modport slave (
        input  axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
        output axis_in_tready,
        output axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
        input  axis_out_tready,
        output pkt_done, err_len, pkt_count, err_count
    );

    modport master (
        output axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
        input  axis_in_tready,
        input  axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
        output axis_out_tready,
        input  pkt_done, err_len, pkt_count, err_count
    );
endinterface

// File: rtl/remove_header.sv
// Strips a one-beat length header from each AXI-Stream packet, forwards payload via a 1-deep register.
// Latency 1 cycle; input stalls only in PAYLOAD when the output register is full and not draining.
module remove_header #(
    parameter int DW = 128
) (
    input  logic           clk,
    input  logic           resetn,
    remove_header_if.slave bus
);
    localparam int KW  = DW / 8;
    localparam int PCW = $clog2(KW + 1);

    typedef enum logic {
        S_HEADER  = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_rst_sync;
    logic            w_rst_n;

    logic [15:0]     r_hdr_len;
    logic [16:0]     r_acc;
    logic [PCW-1:0]  w_popcnt;
    logic [17:0]     w_sum;
    logic [16:0]     w_final;
    logic            w_len_ok;

    logic            w_in_rdy;
    logic            w_hdr_acc;
    logic            w_pay_acc;
    logic            w_pkt_end;
    logic            w_err;

    logic [DW-1:0]   r_out_dat;
    logic [KW-1:0]   r_out_keep;
    logic            r_out_last;
    logic            r_out_vld;
    logic            r_pkt_done;
    logic            r_err_len;
    logic [31:0]     r_pkt_count;
    logic [15:0]     r_err_count;

    // Assert asynchronously, release on the clock so every flop leaves reset in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < KW; i++) begin
            w_popcnt = w_popcnt + PCW'(bus.axis_in_tkeep[i]);
        end
    end

    // Saturated 0x1FFFF can never equal a 16-bit declared length, so it always flags.
    assign w_sum    = {1'b0, r_acc} + 18'(w_popcnt);
    assign w_final  = w_sum[17] ? 17'h1FFFF : w_sum[16:0];
    assign w_len_ok = (w_final == {1'b0, r_hdr_len});

    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_hdr_acc   = 1'b0;
        w_pay_acc   = 1'b0;
        w_pkt_end   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_HEADER: begin
                w_in_rdy = w_rst_n;
                if (bus.axis_in_tvalid && w_in_rdy) begin
                    w_hdr_acc = 1'b1;
                    if (bus.axis_in_tlast) w_err = 1'b1;
                    else                   w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_in_rdy = !r_out_vld || bus.axis_out_tready;
                if (bus.axis_in_tvalid && w_in_rdy) begin
                    w_pay_acc = 1'b1;
                    if (bus.axis_in_tlast) begin
                        w_pkt_end   = 1'b1;
                        w_err       = !w_len_ok;
                        w_state_nxt = S_HEADER;
                    end
                end
            end
            default: w_state_nxt = S_HEADER;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= S_HEADER;
            r_hdr_len <= '0;
            r_acc     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hdr_acc) begin
                r_hdr_len <= bus.axis_in_tdata[15:0];
                r_acc     <= '0;
            end else if (w_pay_acc) begin
                r_acc <= w_final;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out_dat  <= '0;
            r_out_keep <= '0;
            r_out_last <= 1'b0;
            r_out_vld  <= 1'b0;
        end else if (w_pay_acc) begin
            r_out_dat  <= bus.axis_in_tdata;
            r_out_keep <= bus.axis_in_tkeep;
            r_out_last <= bus.axis_in_tlast;
            r_out_vld  <= 1'b1;
        end else if (bus.axis_out_tready) begin
            r_out_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pkt_done  <= 1'b0;
            r_err_len   <= 1'b0;
            r_pkt_count <= '0;
            r_err_count <= '0;
        end else begin
            r_pkt_done <= w_pkt_end;
            r_err_len  <= w_err;
            if (w_pkt_end)                        r_pkt_count <= r_pkt_count + 32'd1;
            if (w_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        end
    end

    assign bus.axis_in_tready  = w_in_rdy;
    assign bus.axis_out_tdata  = r_out_dat;
    assign bus.axis_out_tkeep  = r_out_keep;
    assign bus.axis_out_tlast  = r_out_last;
    assign bus.axis_out_tvalid = r_out_vld;
    assign bus.pkt_done        = r_pkt_done;
    assign bus.err_len         = r_err_len;
    assign bus.pkt_count       = r_pkt_count;
    assign bus.err_count       = r_err_count;
endmodule

// File: tb/tb_remove_header.sv
// Scoreboard bench for remove_header: driver pushes expected payload beats, monitor pops on output handshakes.
module tb_remove_header;
    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    remove_header_if #(.DW(DW)) bus ();
    remove_header #(.DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    beat_t         exp_q[$];
    bit            exp_err_q[$];
    beat_t         mon_e;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            rdy_pct = 100;
    int            out_beats = 0;
    int            err_pulses = 0;
    int            done_pulses = 0;
    int            exp_pkt = 0;
    int            exp_errc = 0;
    int            exp_beats = 0;
    longint        cyc = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] held_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bus.axis_out_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.axis_out_tready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Monitor: everything it samples is stable from posedge+1 to the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && prev_stall && bus.axis_out_tvalid)
                check("hold_tdata", bus.axis_out_tdata, held_d);
            prev_stall = resetn && bus.axis_out_tvalid && !bus.axis_out_tready;
            held_d     = bus.axis_out_tdata;
            if (resetn && bus.axis_out_tvalid && bus.axis_out_tready) begin
                out_beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_tdata", bus.axis_out_tdata, mon_e.d);
                    check("out_tkeep", bus.axis_out_tkeep, mon_e.k);
                    check("out_tlast", bus.axis_out_tlast, mon_e.l);
                end
            end
            if (bus.pkt_done) begin
                done_pulses++;
                check("done_with_last_beat", bus.axis_out_tvalid && bus.axis_out_tlast, 1);
                if (exp_err_q.size() == 0) check("unexpected_pkt_done", 1, 0);
                else                       check("err_with_done", bus.err_len, exp_err_q.pop_front());
            end
            if (bus.err_len) err_pulses++;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                        input bit is_hdr, input bit e);
        int n = 0;
        bus.axis_in_tvalid = 1'b1;
        bus.axis_in_tdata  = d;
        bus.axis_in_tkeep  = k;
        bus.axis_in_tlast  = l;
        while (!bus.axis_in_tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.axis_in_tready) begin
            check("in_tready_timeout", 0, 1);
        end else begin
            if (!is_hdr) begin
                exp_q.push_back('{d, k, l});
                exp_beats++;
                if (l) exp_err_q.push_back(e);
            end
            @(negedge clk);
        end
    endtask

    task automatic send_hdr(input int hlen, input logic last);
        logic [DW-1:0] d;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        d[15:0] = hlen[15:0];
        send(d, KW'($urandom()), last, 1'b1, 1'b0);
    endtask

    // Payload of nbytes with contiguous tkeep; nbytes==0 sends one beat with tkeep=0.
    task automatic send_pkt(input int hlen, input int nbytes);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int  nb;
        int  rem;
        bit  e;
        nb = (nbytes == 0) ? 1 : (nbytes + KW - 1) / KW;
        e  = (hlen != nbytes);
        send_hdr(hlen, 1'b0);
        for (int i = 0; i < nb; i++) begin
            rem = nbytes - i * KW;
            for (int j = 0; j < KW; j++) k[j] = (j < rem);
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(d, k, (i == nb - 1), 1'b0, e);
        end
        exp_pkt++;
        if (e) exp_errc++;
    endtask

    task automatic idle();
        bus.axis_in_tvalid = 1'b0;
        bus.axis_in_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt_count"}, bus.pkt_count, exp_pkt);
        check({tag, "_err_count"}, bus.err_count, exp_errc);
        check({tag, "_out_beats"}, out_beats, exp_beats);
    endtask

    initial begin
        longint t0;
        logic [DW-1:0] d;
        bus.axis_in_tvalid = 1'b0;
        bus.axis_in_tdata  = '0;
        bus.axis_in_tkeep  = '0;
        bus.axis_in_tlast  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_tready", bus.axis_in_tready, 0);
        check("rst_out_tvalid", bus.axis_out_tvalid, 0);
        check("rst_out_tdata", bus.axis_out_tdata, 0);
        check("rst_out_tkeep", bus.axis_out_tkeep, 0);
        check("rst_out_tlast", bus.axis_out_tlast, 0);
        check("rst_pkt_done", bus.pkt_done, 0);
        check("rst_err_len", bus.err_len, 0);
        check("rst_pkt_count", bus.pkt_count, 0);
        check("rst_err_count", bus.err_count, 0);
        resetn = 1'b1;
        @(negedge clk);

        // 40 bytes: tkeep FFFF, FFFF, 00FF
        send_pkt(40, 40);
        drain();
        check_counts("basic");
        check("basic_done_pulses", done_pulses, 1);
        check("basic_err_pulses", err_pulses, 0);

        // declared 48, carried 28: tkeep FFFF, 0FFF
        send_pkt(48, 28);
        drain();
        check_counts("mismatch");
        check("mismatch_err_pulses", err_pulses, 1);

        send_hdr(5, 1'b1);
        exp_errc++;
        drain();
        check_counts("empty");
        check("empty_err_pulses", err_pulses, 2);
        check("empty_done_pulses", done_pulses, 2);
        send_pkt(16, 16);
        drain();
        check_counts("after_empty");

        send_pkt(0, 0);
        send_hdr(8, 1'b0);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 16'hA5A5, 1'b1, 1'b0, 1'b0);
        exp_pkt++;
        drain();
        check_counts("boundary");

        for (int p = 0; p < 100; p++) begin
            rdy_pct = $urandom_range(30, 100);
            send_pkt($urandom_range(1, 2000), -1 + 1 + 0);
        end
        drain();
        check_counts("random_zero");
        for (int p = 0; p < 100; p++) begin
            int len;
            len = $urandom_range(1, 2000);
            rdy_pct = $urandom_range(30, 100);
            send_pkt(len, len);
        end
        drain();
        check_counts("random");

        rdy_pct = 100;
        repeat (2) @(negedge clk);
        t0 = cyc;
        for (int p = 0; p < 4; p++) send_pkt(64, 64);
        check("throughput_cycles", cyc - t0, 20);
        drain();
        check_counts("throughput");

        send_hdr(40, 1'b0);
        for (int i = 0; i < 2; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(d, '1, 1'b0, 1'b0, 1'b0);
        end
        idle();
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_out_tvalid", bus.axis_out_tvalid, 0);
        check("midrst_in_tready", bus.axis_in_tready, 0);
        check("midrst_pkt_count", bus.pkt_count, 0);
        check("midrst_err_count", bus.err_count, 0);
        exp_q.delete();
        exp_err_q.delete();
        exp_pkt   = 0;
        exp_errc  = 0;
        out_beats = 0;
        exp_beats = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send_pkt(40, 40);
        drain();
        check_counts("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
